// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package rv_mem_pkg;
  localparam int XLEN = 32;
  localparam int BE_W = 4;

  // Which requester owns the read that is returning this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and BRAM signals around mem_arbiter.
// Handshake: a requester raises *_req with a stable payload and holds both until
// *_ready is high in the same cycle; that cycle is the transfer. *_rvalid follows one cycle later.
interface mem_arbiter_if #(
  parameter int MEM_AW = 12
);
  import rv_mem_pkg::*;

  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_ready;
  logic              if_rvalid;
  logic [XLEN-1:0]   if_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic              d_ready;
  logic              d_rvalid;
  logic [XLEN-1:0]   d_rdata;

  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_grant.sv
// Fetch/data priority decision with a saturating starvation counter for fetch.
module mem_arb_grant #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_req,
  input  logic       d_req,
  output logic       gnt_if,
  output logic       gnt_d,
  output logic [3:0] starve_cnt
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (rst_n) begin
      if (if_req && d_req) begin
        // Data wins unless fetch has been denied LIMIT cycles in a row.
        if (starve_cnt_q == LIMIT) gnt_if = 1'b1;
        else                       gnt_d  = 1'b1;
      end else if (if_req) begin
        gnt_if = 1'b1;
      end else if (d_req) begin
        gnt_d = 1'b1;
      end
    end

    starve_cnt_d = starve_cnt_q;
    if (!if_req || gnt_if)         starve_cnt_d = 4'd0;
    else if (starve_cnt_q < LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_cnt_q <= 4'd0;
    else        starve_cnt_q <= starve_cnt_d;
  end

  assign starve_cnt = starve_cnt_q;
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port 1-cycle-latency BRAM between instruction fetch and load/store,
// routing read data back to the requester that issued it.
module mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int          MEM_AW       = 12,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus,
  output owner_t        dbg_owner,
  output logic [3:0]    dbg_starve_cnt
);
  logic   gnt_if, gnt_d;
  owner_t owner_q, owner_d;
  logic   unused_addr_bits;

  mem_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .gnt_if     (gnt_if),
    .gnt_d      (gnt_d),
    .starve_cnt (dbg_starve_cnt)
  );

  assign bus.if_ready  = gnt_if;
  assign bus.d_ready   = gnt_d;
  assign bus.mem_en    = gnt_if | gnt_d;
  assign bus.mem_addr  = gnt_if ? bus.if_addr[MEM_AW+1:2] : bus.d_addr[MEM_AW+1:2];
  assign bus.mem_we    = (gnt_d && bus.d_we) ? bus.d_be : '0;
  assign bus.mem_wdata = bus.d_wdata;

  // Byte offset and bits above the memory size are dropped so addresses wrap.
  assign unused_addr_bits = ^{bus.if_addr[XLEN-1:MEM_AW+2], bus.if_addr[1:0],
                              bus.d_addr[XLEN-1:MEM_AW+2], bus.d_addr[1:0]};

  always_comb begin
    owner_d = OWN_NONE;
    if (gnt_if)                  owner_d = OWN_IF;
    else if (gnt_d && !bus.d_we) owner_d = OWN_D;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
  end

  // Gating with rst_n kills the response of a read accepted just before reset.
  assign bus.if_rvalid = rst_n && (owner_q == OWN_IF);
  assign bus.d_rvalid  = rst_n && (owner_q == OWN_D);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign dbg_owner     = owner_q;
endmodule
